triangle_decoder: RTL and testbench

Receive-side companion to the triangle/sawtooth value generator. Consumes a VAL_BITS-wide waveform value, tracks slope direction, flags peaks and troughs, and measures the peak-to-peak period in clock cycles. Sits downstream of any generated waveform bus, e.g. on an LED/PWM test path, to confirm that the waveform is alive and to report its frequency.

---
 rtl/triangle_decoder_if.sv | 17 +
 rtl/triangle_decoder.sv | 92 +++++++++
 tb/tb_triangle_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/triangle_decoder_if.sv
// triangle_decoder_if: waveform sample towards the decoder, slope/peak/period status back
interface triangle_decoder_if #(
  parameter int VAL_BITS = 8,
  parameter int PER_BITS = 32
);
  logic [VAL_BITS-1:0] val;
  logic                dir;
  logic                dir_valid;
  logic                peak;
  logic                trough;
  logic [PER_BITS-1:0] period;
  logic                period_valid;
  logic                locked;
  logic                ovf;
  modport master (output val, input dir, dir_valid, peak, trough, period, period_valid, locked, ovf);
  modport slave (input val, output dir, dir_valid, peak, trough, period, period_valid, locked, ovf);
endinterface

// File: rtl/triangle_decoder.sv
// triangle_decoder: debounced slope tracking, peak/trough pulses and peak-to-peak period measurement
module triangle_decoder #(
  parameter int VAL_BITS  = 8,
  parameter int PER_BITS  = 32,
  parameter int MIN_STEPS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  triangle_decoder_if.slave s_if
);
  localparam int CW = $clog2(MIN_STEPS + 1);
  typedef enum logic [1:0] {ACQUIRE, RISING, FALLING} state_t;
  state_t              r_state, w_state_nx;
  logic [VAL_BITS-1:0] r_val_q;
  logic [CW-1:0]       r_cnt, w_cnt_nx, w_cnt_inc;
  logic [PER_BITS-1:0] r_per_ctr, r_period;
  logic                r_have_peak, r_dir, r_dir_valid, r_peak, r_trough, r_period_valid, r_locked, r_ovf;
  logic                w_up, w_down, w_reach, w_peak, w_trough, w_ctr_max, w_measure;
  assign w_up      = s_if.val > r_val_q;
  assign w_down    = s_if.val < r_val_q;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_reach   = w_cnt_inc == CW'(MIN_STEPS);
  assign w_ctr_max = &r_per_ctr;
  assign w_measure = w_peak & r_have_peak;
  // flat samples fall through every branch untouched, so plateaus never disturb the debounce
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_peak     = 1'b0;
    w_trough   = 1'b0;
    case (r_state)
      RISING:
        if (w_up) w_cnt_nx = '0;
        else if (w_down) begin
          w_peak     = w_reach;
          w_state_nx = w_reach ? FALLING : RISING;
          w_cnt_nx   = w_reach ? '0 : w_cnt_inc;
        end
      FALLING:
        if (w_down) w_cnt_nx = '0;
        else if (w_up) begin
          w_trough   = w_reach;
          w_state_nx = w_reach ? RISING : FALLING;
          w_cnt_nx   = w_reach ? '0 : w_cnt_inc;
        end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = w_up ? RISING : w_down ? FALLING : ACQUIRE;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_val_q        <= '0;
      r_state        <= ACQUIRE;
      r_cnt          <= '0;
      r_per_ctr      <= '0;
      r_have_peak    <= 1'b0;
      r_dir          <= 1'b0;
      r_dir_valid    <= 1'b0;
      r_peak         <= 1'b0;
      r_trough       <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_ovf          <= 1'b0;
    end else begin
      r_val_q        <= s_if.val;
      r_state        <= w_state_nx;
      r_cnt          <= w_cnt_nx;
      r_per_ctr      <= w_peak ? PER_BITS'(1) : w_ctr_max ? r_per_ctr : r_per_ctr + 1'b1;
      r_have_peak    <= r_have_peak | w_peak;
      r_dir          <= w_state_nx == RISING;
      r_dir_valid    <= w_state_nx != ACQUIRE;
      r_peak         <= w_peak;
      r_trough       <= w_trough;
      r_period_valid <= w_measure;
      r_locked       <= r_locked | w_measure;
      if (w_measure) begin
        r_period <= r_per_ctr;
        r_ovf    <= w_ctr_max;
      end
    end
  assign s_if.dir          = r_dir;
  assign s_if.dir_valid    = r_dir_valid;
  assign s_if.peak         = r_peak;
  assign s_if.trough       = r_trough;
  assign s_if.period       = r_period;
  assign s_if.period_valid = r_period_valid;
  assign s_if.locked       = r_locked;
  assign s_if.ovf          = r_ovf;
endmodule

// File: tb/tb_triangle_decoder.sv
// tb_triangle_decoder: directed scoreboard checks of slope, peak/trough, period and reset
module tb_triangle_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] val = 8'd0;
  always #5 clk = ~clk;
  triangle_decoder_if #(.VAL_BITS(8), .PER_BITS(32)) a_if ();
  triangle_decoder_if #(.VAL_BITS(8), .PER_BITS(32)) b_if ();
  triangle_decoder_if #(.VAL_BITS(8), .PER_BITS(4)) c_if ();
  assign a_if.val = val;
  assign b_if.val = val;
  assign c_if.val = val;
  triangle_decoder #(.VAL_BITS(8), .PER_BITS(32), .MIN_STEPS(1)) u_a (.i_clk(clk), .i_rst_n(rst_n), .s_if(a_if.slave));
  triangle_decoder #(.VAL_BITS(8), .PER_BITS(32), .MIN_STEPS(2)) u_b (.i_clk(clk), .i_rst_n(rst_n), .s_if(b_if.slave));
  triangle_decoder #(.VAL_BITS(8), .PER_BITS(4), .MIN_STEPS(1)) u_c (.i_clk(clk), .i_rst_n(rst_n), .s_if(c_if.slave));
  typedef struct {
    string       tag;
    logic [38:0] e;
  } sb_t;
  sb_t         q[$];
  int          errors = 0;
  int          checks = 0;
  int          sel = 1;
  int          cyc = 0;
  int          last_pk = -1;
  logic        held_lk = 1'b0;
  logic        held_ovf = 1'b0;
  logic [31:0] held_per = 32'd0;
  int          pb_v[10] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
  logic [3:0]  pb_e[10] = '{4'b0000, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0111};
  int          pat8[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
  int          db_v[12] = '{1, 2, 3, 2, 3, 4, 4, 3, 2, 1, 2, 3};
  logic [3:0]  db_e[12] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                            4'b1001, 4'b0001, 4'b0001, 4'b0111};
  function automatic logic [38:0] obs();
    case (sel)
      1: return {a_if.peak, a_if.trough, a_if.dir, a_if.dir_valid, a_if.period_valid, a_if.locked, a_if.ovf, a_if.period};
      2: return {b_if.peak, b_if.trough, b_if.dir, b_if.dir_valid, b_if.period_valid, b_if.locked, b_if.ovf, b_if.period};
      default: return {c_if.peak, c_if.trough, c_if.dir, c_if.dir_valid, c_if.period_valid, c_if.locked, c_if.ovf, 28'd0, c_if.period};
    endcase
  endfunction
  task automatic push(input string tag, input logic pk, tr, dr, dv, pv);
    sb_t s;
    s.tag = tag;
    s.e = {pk, tr, dr, dv, pv, held_lk, held_ovf, held_per};
    q.push_back(s);
  endtask
  task automatic check_pop();
    sb_t s;
    logic [38:0] o;
    s = q.pop_front();
    o = obs();
    checks++;
    assert (o === s.e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", s.tag, o, s.e);
    end
  endtask
  task automatic step(input string tag, input logic [7:0] v, input logic pk, tr, dr, dv,
                      input logic pv = 1'b0, input logic [31:0] per = 32'd0, input logic ov = 1'b0);
    @(negedge clk);
    val = v;
    if (pv) begin
      held_per = per;
      held_ovf = ov;
      held_lk  = 1'b1;
    end
    push(tag, pk, tr, dr, dv, pv);
    @(posedge clk);
    #1;
    cyc++;
    check_pop();
  endtask
  task automatic clear_model();
    held_per = 32'd0;
    held_ovf = 1'b0;
    held_lk  = 1'b0;
    last_pk  = -1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    val = 8'd0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic run_tri(input int h, input int n, input bit fresh);
    int p;
    p = 2 * h;
    for (int j = 0; j < n * p; j++) begin
      int m;
      int k;
      logic pk;
      logic pv;
      m  = j % p;
      pk = m == h + 1;
      k  = cyc - last_pk;
      pv = pk && last_pk >= 0;
      if (pk) last_pk = cyc;
      step($sformatf("sat_h%0d_j%0d", h, j), 8'(m <= h ? m : p - m), pk, m == 1 && (j >= p || !fresh),
           m >= 1 && m <= h, !(fresh && j == 0), pv, k >= 15 ? 32'd15 : 32'(k), k >= 15);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 3; i++) step("reset_hold", i[0] ? 8'hFF : 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("acq_flat", 8'd0, 0, 0, 0, 0);
    step("acq_up", 8'd1, 0, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 10; i++) step($sformatf("pktr_%0d", i), 8'(pb_v[i]), pb_e[i][3], pb_e[i][2], pb_e[i][1], pb_e[i][0]);
    do_reset();
    for (int i = 0; i < 32; i++) begin
      int m;
      m = i % 8;
      step($sformatf("per_%0d", i), 8'(pat8[m]), m == 5, m == 1 && i >= 8, m >= 1 && m <= 4, i >= 1,
           m == 5 && i >= 13, 32'd8, 1'b0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    push("async_reset", 0, 0, 0, 0, 0);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;
    sel = 2;
    do_reset();
    for (int i = 0; i < 12; i++) step($sformatf("deb_%0d", i), 8'(db_v[i]), db_e[i][3], db_e[i][2], db_e[i][1], db_e[i][0]);
    sel = 3;
    do_reset();
    run_tri(10, 3, 1'b1);
    run_tri(5, 3, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
